// File: rtl/rv32v_cfg_csr_unit.sv
// Vector configuration (vsetvl/vsetvli/vsetivli) responder and vector CSR file.
// Define RV32V_FRACTIONAL_LMUL_EN to accept fractional LMUL; otherwise mf2/mf4/mf8 raise vill.
module rv32v_cfg_csr_unit #(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cfg_req,
  input  logic [1:0]  cfg_type,
  input  logic [31:0] cfg_avl,
  input  logic [31:0] cfg_vtype,
  input  logic        cfg_keepvl,
  input  logic        cfg_rs1_x0,
  output logic        cfg_ack,
  output logic [31:0] cfg_vl_out,
  input  logic        csr_ren,
  input  logic        csr_wen,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_ready,
  output logic        csr_illegal,
  input  logic        vxsat_set,
  input  logic        vstart_clr,
  output logic [31:0] vl,
  output logic [31:0] vtype,
  output logic [31:0] vlmax,
  output logic [31:0] vstart,
  output logic [1:0]  vxrm
);
  localparam int VLEN_WIDTH = $clog2(VLEN);
  localparam int VS_W       = VLEN_WIDTH + 1;

  localparam logic [1:0]  NOT_CFG    = 2'd0;
  localparam logic [11:0] CSR_VSTART = 12'h008;
  localparam logic [11:0] CSR_VXSAT  = 12'h009;
  localparam logic [11:0] CSR_VXRM   = 12'h00A;
  localparam logic [11:0] CSR_VCSR   = 12'h00F;
  localparam logic [11:0] CSR_VL     = 12'hC20;
  localparam logic [11:0] CSR_VTYPE  = 12'hC21;
  localparam logic [11:0] CSR_VLENB  = 12'hC22;

  localparam logic [31:0] VILL_VTYPE = 32'h8000_0000;
  localparam logic [31:0] VLEN_32    = 32'(VLEN);
  localparam logic [31:0] ELEN_32    = 32'(ELEN);
  localparam logic [31:0] VLENB_32   = 32'(VLEN / 8);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [31:0]     lat_avl;
  logic [30:0]     lat_vtype;
  logic            lat_keepvl, lat_rs1_x0;
  logic [31:0]     vl_q, vtype_q, vlmax_q, cfg_vl_q;
  logic [VS_W-1:0] vstart_q;
  logic [1:0]      vxrm_q;
  logic            vxsat_q;
  logic            cfg_start;

  assign cfg_start = cfg_req && (cfg_type != NOT_CFG);

  // FSM
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cfg_ack   = 1'b0;
    csr_ready = 1'b0;
    case (state_q)
      IDLE: begin
        csr_ready = 1'b1;
        if (cfg_start) state_d = CALC;
      end
      CALC: state_d = DONE;
      DONE: begin
        cfg_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // VLMAX / vill / vl computation from the latched request
  logic [2:0]  c_sew, c_lmul;
  logic [31:0] sew_bits, calc_vlmax, calc_vl;
  logic        calc_vill;

  assign c_sew    = lat_vtype[5:3];
  assign c_lmul   = lat_vtype[2:0];
  assign sew_bits = 32'd8 << c_sew;

  always_comb begin
    calc_vill  = 1'b0;
    calc_vlmax = '0;
    calc_vl    = '0;
    if (sew_bits > ELEN_32)       calc_vill = 1'b1;
    if (lat_vtype[30:8] != '0)    calc_vill = 1'b1;
    if (!c_lmul[2]) begin
      calc_vlmax = (VLEN_32 << c_lmul) >> ({2'b0, c_sew} + 5'd3);
    end else if (c_lmul == 3'd4) begin
      calc_vill = 1'b1;
    end else begin
`ifdef RV32V_FRACTIONAL_LMUL_EN
      // SEW must fit in ELEN*LMUL, i.e. SEW * 2^(8-vlmul) <= ELEN
      if ((sew_bits << (5'd8 - {2'b0, c_lmul})) > ELEN_32) calc_vill = 1'b1;
      calc_vlmax = (VLEN_32 >> ({2'b0, c_sew} + 5'd3)) >> (5'd8 - {2'b0, c_lmul});
`else
      calc_vill = 1'b1;
`endif
    end
    if (calc_vlmax == '0) calc_vill = 1'b1;

    if (lat_keepvl)      calc_vl = (vl_q < calc_vlmax) ? vl_q : calc_vlmax;
    else if (lat_rs1_x0) calc_vl = calc_vlmax;
    else                 calc_vl = (lat_avl < calc_vlmax) ? lat_avl : calc_vlmax;
  end

  // CSR decode
  logic addr_ok, addr_ro, csr_we;

  always_comb begin
    csr_rdata = '0;
    addr_ok   = 1'b1;
    addr_ro   = 1'b0;
    case (csr_addr)
      CSR_VSTART: csr_rdata = {{(32-VS_W){1'b0}}, vstart_q};
      CSR_VXSAT:  csr_rdata = {31'b0, vxsat_q};
      CSR_VXRM:   csr_rdata = {30'b0, vxrm_q};
      CSR_VCSR:   csr_rdata = {29'b0, vxrm_q, vxsat_q};
      CSR_VL:     begin csr_rdata = vl_q;     addr_ro = 1'b1; end
      CSR_VTYPE:  begin csr_rdata = vtype_q;  addr_ro = 1'b1; end
      CSR_VLENB:  begin csr_rdata = VLENB_32; addr_ro = 1'b1; end
      default:    addr_ok = 1'b0;
    endcase
  end

  assign csr_illegal = csr_ready &&
                       ((csr_ren && !addr_ok) || (csr_wen && (!addr_ok || addr_ro)));
  assign csr_we      = csr_ready && csr_wen && !csr_illegal;

  // Architectural state
  always_ff @(posedge CLK) begin
    if (RST) begin
      lat_avl    <= '0;
      lat_vtype  <= '0;
      lat_keepvl <= 1'b0;
      lat_rs1_x0 <= 1'b0;
      vl_q       <= '0;
      vtype_q    <= VILL_VTYPE;
      vlmax_q    <= '0;
      cfg_vl_q   <= '0;
      vstart_q   <= '0;
      vxrm_q     <= '0;
      vxsat_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && cfg_start) begin
        lat_avl    <= cfg_avl;
        lat_vtype  <= cfg_vtype[30:0];
        lat_keepvl <= cfg_keepvl;
        lat_rs1_x0 <= cfg_rs1_x0;
      end

      if (state_q == CALC) begin
        vl_q     <= calc_vill ? '0 : calc_vl;
        cfg_vl_q <= calc_vill ? '0 : calc_vl;
        vlmax_q  <= calc_vill ? '0 : calc_vlmax;
        vtype_q  <= calc_vill ? VILL_VTYPE : {24'b0, lat_vtype[7:0]};
        vstart_q <= '0;
      end else if (csr_we && csr_addr == CSR_VSTART) begin
        vstart_q <= csr_wdata[VS_W-1:0];
      end else if (vstart_clr) begin
        vstart_q <= '0;
      end

      // vxsat is sticky: a lane saturation in the write cycle survives the write
      if (csr_we && (csr_addr == CSR_VXSAT || csr_addr == CSR_VCSR))
        vxsat_q <= csr_wdata[0] | vxsat_set;
      else if (vxsat_set)
        vxsat_q <= 1'b1;

      if (csr_we && csr_addr == CSR_VXRM)      vxrm_q <= csr_wdata[1:0];
      else if (csr_we && csr_addr == CSR_VCSR) vxrm_q <= csr_wdata[2:1];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{cfg_vtype[31], csr_wdata[31:VS_W]};

  assign cfg_vl_out = cfg_vl_q;
  assign vl         = vl_q;
  assign vtype      = vtype_q;
  assign vlmax      = vlmax_q;
  assign vstart     = {{(32-VS_W){1'b0}}, vstart_q};
  assign vxrm       = vxrm_q;
endmodule

// File: tb/tb_rv32v_cfg_csr_unit.sv
// Scoreboard bench for rv32v_cfg_csr_unit: stimulus queues expectations, a monitor checks acks and CSR accesses.
module tb_rv32v_cfg_csr_unit;
  localparam logic [11:0] A_VSTART = 12'h008, A_VXSAT = 12'h009, A_VXRM = 12'h00A,
                          A_VCSR = 12'h00F, A_VL = 12'hC20, A_VTYPE = 12'hC21,
                          A_VLENB = 12'hC22, A_BAD = 12'h123;
  localparam logic [31:0] VILL = 32'h8000_0000;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        cfg_req = 0, cfg_keepvl = 0, cfg_rs1_x0 = 0;
  logic [1:0]  cfg_type = 0;
  logic [31:0] cfg_avl = 0, cfg_vtype = 0;
  logic        cfg_ack;
  logic [31:0] cfg_vl_out;
  logic        csr_ren = 0, csr_wen = 0;
  logic [11:0] csr_addr = 0;
  logic [31:0] csr_wdata = 0, csr_rdata;
  logic        csr_ready, csr_illegal;
  logic        vxsat_set = 0, vstart_clr = 0;
  logic [31:0] vl, vtype, vlmax, vstart;
  logic [1:0]  vxrm;

  rv32v_cfg_csr_unit #(.VLEN(128), .ELEN(32)) dut (
    .CLK(CLK), .RST(RST),
    .cfg_req(cfg_req), .cfg_type(cfg_type), .cfg_avl(cfg_avl), .cfg_vtype(cfg_vtype),
    .cfg_keepvl(cfg_keepvl), .cfg_rs1_x0(cfg_rs1_x0), .cfg_ack(cfg_ack), .cfg_vl_out(cfg_vl_out),
    .csr_ren(csr_ren), .csr_wen(csr_wen), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_ready(csr_ready), .csr_illegal(csr_illegal),
    .vxsat_set(vxsat_set), .vstart_clr(vstart_clr),
    .vl(vl), .vtype(vtype), .vlmax(vlmax), .vstart(vstart), .vxrm(vxrm)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] vl; logic [31:0] vtype; logic [31:0] vlmax; int cyc; } cfg_exp_t;
  typedef struct { logic chk_rd; logic [31:0] rdata; logic ill; string nm; } csr_exp_t;

  cfg_exp_t cq[$];
  csr_exp_t sq[$];
  int n_vec = 0, n_err = 0, cyc = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the head of the queues
  always @(negedge CLK) begin : monitor
    cfg_exp_t ce;
    csr_exp_t se;
    if (!RST && cfg_ack) begin
      if (cq.size() == 0) chk("unexpected_ack", {31'b0, cfg_ack}, 32'd0);
      else begin
        ce = cq.pop_front();
        chk("ack_latency", cyc - ce.cyc, 32'd2);
        chk("cfg_vl_out", cfg_vl_out, ce.vl);
        chk("vl", vl, ce.vl);
        chk("vtype", vtype, ce.vtype);
        chk("vlmax", vlmax, ce.vlmax);
      end
    end
    if (!RST && (csr_ren || csr_wen) && csr_ready) begin
      if (sq.size() == 0) chk("unexpected_csr", {20'b0, csr_addr}, 32'd0);
      else begin
        se = sq.pop_front();
        if (se.chk_rd) chk({se.nm, "_rdata"}, csr_rdata, se.rdata);
        chk({se.nm, "_illegal"}, {31'b0, csr_illegal}, {31'b0, se.ill});
      end
    end
  end

  task automatic do_cfg(input logic [1:0] t, input logic [31:0] avl, input logic [31:0] vt,
                        input logic keep, input logic x0,
                        input logic [31:0] evl, input logic [31:0] evt, input logic [31:0] evm);
    bit got;
    got = 0;
    cq.push_back('{evl, evt, evm, cyc});
    cfg_req = 1; cfg_type = t; cfg_avl = avl; cfg_vtype = vt; cfg_keepvl = keep; cfg_rs1_x0 = x0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge CLK);
      got = cfg_ack;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL cfg_timeout: no cfg_ack, want cfg_ack within 8 cycles");
      cq.delete();
    end
    @(posedge CLK); #1;
    cfg_req = 0; cfg_type = 0; cfg_keepvl = 0; cfg_rs1_x0 = 0;
  endtask

  task automatic csr_op(input string nm, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                        input logic sat, input logic clr,
                        input logic chk_rd, input logic [31:0] erd, input logic eill);
    sq.push_back('{chk_rd, erd, eill, nm});
    csr_wen = wr; csr_ren = !wr; csr_addr = a; csr_wdata = wd; vxsat_set = sat; vstart_clr = clr;
    @(posedge CLK); #1;
    csr_wen = 0; csr_ren = 0; vxsat_set = 0; vstart_clr = 0;
  endtask

  task automatic pulse(input logic sat, input logic clr);
    vxsat_set = sat; vstart_clr = clr;
    @(posedge CLK); #1;
    vxsat_set = 0; vstart_clr = 0;
  endtask

  initial begin
    bit saw;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    @(negedge CLK);
    chk("rst_vl", vl, 32'd0);
    chk("rst_vtype", vtype, VILL);
    chk("rst_vlmax", vlmax, 32'd0);
    chk("rst_vstart", vstart, 32'd0);
    chk("rst_vxrm", {30'b0, vxrm}, 32'd0);
    chk("rst_ack", {31'b0, cfg_ack}, 32'd0);
    chk("rst_vl_out", cfg_vl_out, 32'd0);
    chk("rst_ready", {31'b0, csr_ready}, 32'd1);
    @(posedge CLK); #1;

    csr_op("w_vstart5", 1, A_VSTART, 32'd5, 0, 0, 0, 0, 0);
    csr_op("r_vstart5", 0, A_VSTART, 0, 0, 0, 1, 32'd5, 0);
    do_cfg(2'd1, 32'd10, 32'h10, 0, 0, 32'd4, 32'h10, 32'd4);          // e32/m1
    csr_op("r_vstart_clr", 0, A_VSTART, 0, 0, 0, 1, 32'd0, 0);
    do_cfg(2'd1, 32'd200, 32'h03, 0, 0, 32'd128, 32'h03, 32'd128);     // e8/m8
    do_cfg(2'd1, 32'hFFFF_FFFF, 32'h03, 0, 0, 32'd128, 32'h03, 32'd128);
    do_cfg(2'd1, 32'd0, 32'h10, 1, 0, 32'd4, 32'h10, 32'd4);           // keepvl
    do_cfg(2'd1, 32'd10, 32'h18, 0, 0, 32'd0, VILL, 32'd0);            // SEW64
    do_cfg(2'd1, 32'd10, 32'h04, 0, 0, 32'd0, VILL, 32'd0);            // vlmul=4
    do_cfg(2'd1, 32'd10, 32'h1010, 0, 0, 32'd0, VILL, 32'd0);          // reserved bit
`ifdef RV32V_FRACTIONAL_LMUL_EN
    do_cfg(2'd1, 32'd0, 32'h0F, 0, 1, 32'd4, 32'h0F, 32'd4);           // e16/mf2
`else
    do_cfg(2'd1, 32'd0, 32'h0F, 0, 1, 32'd0, VILL, 32'd0);
`endif
    do_cfg(2'd1, 32'd0, 32'h05, 0, 1, 32'd0, VILL, 32'd0);             // e8/mf8
    do_cfg(2'd3, 32'd1, 32'hD0, 0, 0, 32'd1, 32'hD0, 32'd4);           // vsetvl, ta/ma
    do_cfg(2'd2, 32'd3, 32'h00, 0, 0, 32'd3, 32'h00, 32'd16);          // vsetivli e8/m1

    // NOT_CFG requests are ignored
    cfg_req = 1; cfg_type = 2'd0; cfg_avl = 32'd50; cfg_vtype = 32'h10;
    saw = 0;
    repeat (4) begin @(negedge CLK); saw |= cfg_ack; end
    chk("not_cfg_ack", {31'b0, saw}, 32'd0);
    chk("not_cfg_vl", vl, 32'd3);
    @(posedge CLK); #1 cfg_req = 0;

    csr_op("w_vl", 1, A_VL, 32'd7, 0, 0, 0, 0, 1);
    csr_op("r_vl", 0, A_VL, 0, 0, 0, 1, 32'd3, 0);
    csr_op("r_vlenb", 0, A_VLENB, 0, 0, 0, 1, 32'd16, 0);
    csr_op("r_vtype", 0, A_VTYPE, 0, 0, 0, 1, 32'd0, 0);
    csr_op("r_bad", 0, A_BAD, 0, 0, 0, 0, 0, 1);
    csr_op("w_bad", 1, A_BAD, 32'd1, 0, 0, 0, 0, 1);
    csr_op("w_vxrm2", 1, A_VXRM, 32'd2, 0, 0, 0, 0, 0);
    pulse(1, 0);
    csr_op("r_vcsr5", 0, A_VCSR, 0, 0, 0, 1, 32'd5, 0);
    csr_op("r_vxrm2", 0, A_VXRM, 0, 0, 0, 1, 32'd2, 0);
    csr_op("w_vxsat0", 1, A_VXSAT, 32'd0, 0, 0, 0, 0, 0);
    csr_op("r_vcsr4", 0, A_VCSR, 0, 0, 0, 1, 32'd4, 0);
    csr_op("w_vxsat0_set", 1, A_VXSAT, 32'd0, 1, 0, 0, 0, 0);
    csr_op("r_vxsat1", 0, A_VXSAT, 0, 0, 0, 1, 32'd1, 0);
    csr_op("w_vcsr2", 1, A_VCSR, 32'd2, 0, 0, 0, 0, 0);
    csr_op("r_vxrm1", 0, A_VXRM, 0, 0, 0, 1, 32'd1, 0);
    csr_op("r_vxsat0", 0, A_VXSAT, 0, 0, 0, 1, 32'd0, 0);
    csr_op("w_vstart1ff", 1, A_VSTART, 32'h1FF, 0, 0, 0, 0, 0);
    csr_op("r_vstart_ff", 0, A_VSTART, 0, 0, 0, 1, 32'hFF, 0);
    pulse(0, 1);
    csr_op("r_vstart_clr2", 0, A_VSTART, 0, 0, 0, 1, 32'd0, 0);
    csr_op("w_vstart9_clr", 1, A_VSTART, 32'd9, 0, 1, 0, 0, 0);
    csr_op("r_vstart9", 0, A_VSTART, 0, 0, 0, 1, 32'd9, 0);

    // Reset while the FSM is in CALC aborts the configuration
    cfg_req = 1; cfg_type = 2'd1; cfg_avl = 32'd3; cfg_vtype = 32'h10;
    @(posedge CLK); #1;
    RST = 1; cfg_req = 0; cfg_type = 0; csr_ren = 1; csr_addr = A_VL;
    @(negedge CLK);
    chk("calc_ready", {31'b0, csr_ready}, 32'd0);
    @(posedge CLK); #1;
    RST = 0; csr_ren = 0;
    saw = 0;
    repeat (4) begin @(negedge CLK); saw |= cfg_ack; end
    chk("abort_ack", {31'b0, saw}, 32'd0);
    chk("abort_vl", vl, 32'd0);
    chk("abort_vtype", vtype, VILL);
    chk("abort_vlmax", vlmax, 32'd0);
    chk("abort_vxrm", {30'b0, vxrm}, 32'd0);
    chk("abort_vstart", vstart, 32'd0);

    chk("cfg_queue_left", cq.size(), 32'd0);
    chk("csr_queue_left", sq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
